// File: rtl/add64_seq_ctrl_pkg.sv
// rtl/add64_seq_ctrl_pkg.sv - shared state encoding, slice width and flag helper for the sequential adder
package add64_seq_ctrl_pkg;

    // Width of the shared carry-lookahead slice.
    localparam int ADDSEQ_SLICE = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } addseq_state_e;

    // Signed overflow: operands agree in sign but the result does not.
    function automatic logic ovf_flag(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/add64_seq_ctrl_if.sv
// rtl/add64_seq_ctrl_if.sv - request/result handshake bundle for the sequential adder
// Request side:  in_valid/in_ready, in_a, in_b, in_cin, in_sub, flush
// Result side:   out_valid/out_ready, out_sum, out_cout, out_ovf, out_zero
// Status:        busy
// master = issue/writeback side, slave = adder controller.
interface add64_seq_ctrl_if #(
    parameter int WIDTH = 64
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;
    logic             busy;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, flush, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, flush, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, busy
    );
endinterface

// File: rtl/add64_seq_ctrl_cla16.sv
// rtl/add64_seq_ctrl_cla16.sv - 16-bit carry-lookahead adder slice (four 4-bit groups)
// Ports: x, y  operands; cin  carry in; f  sum; cout  carry out of bit 15.
module add64_seq_ctrl_cla16 (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        cin,
    output logic [15:0] f,
    output logic        cout
);
    logic [15:0] g;
    logic [15:0] p;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;
    logic        cc;

    always_comb begin
        g  = x & y;
        p  = x ^ y;
        gg = '0;
        gp = '0;
        gc = '0;
        f  = '0;
        cc = 1'b0;

        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end

        // Group carries resolved in parallel from the group generate/propagate terms.
        gc[0] = cin;
        gc[1] = gg[0] | (gp[0] & cin);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & cin);
        gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

        // Carries inside each 4-bit group only ripple from that group's lookahead carry.
        for (int k = 0; k < 4; k++) begin
            cc = gc[k];
            for (int j = 0; j < 4; j++) begin
                f[4*k+j] = p[4*k+j] ^ cc;
                cc       = g[4*k+j] | (p[4*k+j] & cc);
            end
        end

        cout = gc[4];
    end
endmodule

// File: rtl/add64_seq_ctrl.sv
// rtl/add64_seq_ctrl.sv - WIDTH-bit add/sub time-multiplexed LSB-first over one 16-bit CLA slice
// Ports: clk, rst_n (async active-low); bus (slave modport of add64_seq_ctrl_if):
//   in_valid/in_ready + in_a, in_b, in_cin, in_sub request; flush kills the in-flight op;
//   out_valid/out_ready + out_sum, out_cout, out_ovf, out_zero result; busy = not idle.
module add64_seq_ctrl
    import add64_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SLICE = ADDSEQ_SLICE
) (
    input  logic              clk,
    input  logic              rst_n,
    add64_seq_ctrl_if.slave   bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    addseq_state_e    state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             a_msb;
    logic             beff_msb;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;
    logic             valid_r;

    logic [SLICE-1:0] slice_sum;
    logic             slice_cout;

    add64_seq_ctrl_cla16 u_slice (
        .x    (a_sh[SLICE-1:0]),
        .y    (b_sh[SLICE-1:0]),
        .cin  (carry),
        .f    (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            a_msb    <= 1'b0;
            beff_msb <= 1'b0;
            sum_r    <= '0;
            cout_r   <= 1'b0;
            ovf_r    <= 1'b0;
            valid_r  <= 1'b0;
        end else if (bus.flush) begin
            // Kill wins over accept and over a same-cycle result handshake.
            state   <= ST_IDLE;
            valid_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_sh     <= bus.in_a;
                        b_sh     <= bus.in_sub ? ~bus.in_b : bus.in_b;
                        carry    <= bus.in_sub | bus.in_cin;
                        a_msb    <= bus.in_a[WIDTH-1];
                        beff_msb <= bus.in_sub ? ~bus.in_b[WIDTH-1] : bus.in_b[WIDTH-1];
                        cnt      <= '0;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    carry <= slice_cout;
                    a_sh  <= a_sh >> SLICE;
                    b_sh  <= b_sh >> SLICE;
                    // The result register doubles as the shift register; each slice enters at the top.
                    sum_r <= (sum_r >> SLICE)
                           | ({{(WIDTH-SLICE){1'b0}}, slice_sum} << (WIDTH - SLICE));
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_W'(NSLICE - 1)) begin
                        state   <= ST_DONE;
                        valid_r <= 1'b1;
                        cout_r  <= slice_cout;
                        ovf_r   <= ovf_flag(a_msb, beff_msb, slice_sum[SLICE-1]);
                        cnt     <= '0;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        valid_r <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.out_valid = valid_r;
    assign bus.out_sum   = sum_r;
    assign bus.out_cout  = cout_r;
    assign bus.out_ovf   = ovf_r;
    // Qualified by out_valid so the flag reads 0 out of reset and while a partial sum is shifting.
    assign bus.out_zero  = valid_r && (sum_r == '0);
endmodule

// File: tb/tb_add64_seq_ctrl.sv
// tb/tb_add64_seq_ctrl.sv - directed self-checking bench for add64_seq_ctrl
module tb_add64_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   lat;

    add64_seq_ctrl_if #(.WIDTH(64)) bus ();

    add64_seq_ctrl #(.WIDTH(64), .SLICE(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents a request at a falling edge and returns the number of falling edges,
    // counted from the accept edge, until out_valid is seen (capped at 20).
    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic cin,
                         input logic sub, output int n);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        bus.in_sub   = sub;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_result(input string tag, input logic [63:0] s, input logic c,
                                input logic o, input logic z);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_sum"},   bus.out_sum,         s);
        check({tag, "_cout"},  64'(bus.out_cout),   64'(c));
        check({tag, "_ovf"},   64'(bus.out_ovf),    64'(o));
        check({tag, "_zero"},  64'(bus.out_zero),   64'(z));
    endtask

    task automatic consume(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_idle_ready"}, 64'(bus.in_ready),  64'd1);
        check({tag, "_idle_valid"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.in_sub    = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy",      64'(bus.busy),      64'd0);
        check("rst_out_sum",   bus.out_sum,        64'd0);
        check("rst_out_cout",  64'(bus.out_cout),  64'd0);
        check("rst_out_ovf",   64'(bus.out_ovf),   64'd0);
        check("rst_out_zero",  64'(bus.out_zero),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // All-ones plus one: carry ripples through every slice.
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, lat);
        check("t1_latency", 64'(lat), 64'd5);
        check_result("t1", 64'd0, 1'b1, 1'b0, 1'b1);
        check("t1_in_ready_done", 64'(bus.in_ready), 64'd0);
        check("t1_busy_done",     64'(bus.busy),     64'd1);
        consume("t1");

        // 0 - 1: borrow out, all-ones result.
        issue(64'd0, 64'd1, 1'b0, 1'b1, lat);
        check("t2_latency", 64'(lat), 64'd5);
        check_result("t2", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
        consume("t2");

        // Largest positive plus one overflows.
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, lat);
        check_result("t3a", 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
        consume("t3a");

        // Carry crosses only the slice 0 / slice 1 boundary.
        issue(64'h0000_FFFF_0000_FFFF, 64'd1, 1'b0, 1'b0, lat);
        check_result("t3b", 64'h0000_FFFF_0001_0000, 1'b0, 1'b0, 1'b0);
        consume("t3b");

        // Carry-in honoured on add, ignored on subtract.
        issue(64'd5, 64'd6, 1'b1, 1'b0, lat);
        check_result("cin_add", 64'd12, 1'b0, 1'b0, 1'b0);
        consume("cin_add");
        issue(64'd9, 64'd4, 1'b1, 1'b1, lat);
        check_result("cin_sub", 64'd5, 1'b1, 1'b0, 1'b0);
        consume("cin_sub");

        // Backpressure: result held for 10 cycles; a new request is refused meanwhile.
        issue(64'd10, 64'd20, 1'b0, 1'b0, lat);
        check_result("t4", 64'd30, 1'b0, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_a     = 64'd99;
        bus.in_b     = 64'd1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_hold_valid", 64'(bus.out_valid), 64'd1);
            check("t4_hold_sum",   bus.out_sum,        64'd30);
            check("t4_hold_ready", 64'(bus.in_ready),  64'd0);
        end
        bus.in_valid = 1'b0;
        consume("t4");
        check("t4_not_queued", 64'(bus.busy), 64'd0);

        // Flush after two RUN edges.
        bus.in_a     = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.in_b     = 64'd1;
        bus.in_cin   = 1'b0;
        bus.in_sub   = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("t5_in_ready", 64'(bus.in_ready), 64'd1);
        check("t5_busy",     64'(bus.busy),     64'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t5_no_valid", 64'(bus.out_valid), 64'd0);
        end
        issue(64'd5, 64'd3, 1'b0, 1'b1, lat);
        check("t5_latency", 64'(lat), 64'd5);
        check_result("t5", 64'd2, 1'b1, 1'b0, 1'b0);
        consume("t5");

        // Flush beats a same-cycle request in IDLE.
        bus.in_a     = 64'd1;
        bus.in_b     = 64'd1;
        bus.in_sub   = 1'b0;
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        check("flush_idle_busy", 64'(bus.busy), 64'd0);

        // Flush beats a same-cycle result handshake in DONE.
        issue(64'd1, 64'd1, 1'b0, 1'b0, lat);
        check_result("flush_done", 64'd2, 1'b0, 1'b0, 1'b0);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        check("flush_done_valid", 64'(bus.out_valid), 64'd0);
        check("flush_done_ready", 64'(bus.in_ready),  64'd1);

        // Asynchronous reset between edges while RUN has shifted in two slices.
        bus.in_a     = 64'h1234_5678_9ABC_DEF0;
        bus.in_b     = 64'h1111_1111_1111_1111;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_in_ready",  64'(bus.in_ready),  64'd1);
        check("t6_out_valid", 64'(bus.out_valid), 64'd0);
        check("t6_busy",      64'(bus.busy),      64'd0);
        check("t6_out_sum",   bus.out_sum,        64'd0);
        check("t6_out_cout",  64'(bus.out_cout),  64'd0);
        check("t6_out_ovf",   64'(bus.out_ovf),   64'd0);
        check("t6_out_zero",  64'(bus.out_zero),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_no_valid_after", 64'(bus.out_valid), 64'd0);
        issue(64'd3, 64'd4, 1'b0, 1'b0, lat);
        check("t6_latency", 64'(lat), 64'd5);
        check_result("t6", 64'd7, 1'b0, 1'b0, 1'b0);
        consume("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
